// File: rtl/frontend_command_definition_pkg.sv
// Frontend command definitions shared by the frontend master, the command
// responder and its FIFO.
//   frontend_command_t : packed {op_type, data_type, row_addr, col_addr}
//   OP_READ / OP_WRITE : the only op_type values the responder forwards
//   DATA_TYPE_*        : data_type encodings (carried, not interpreted here)
//   fe_slave_state_t   : responder FSM state (INIT, RUN)
package frontend_command_definition_pkg;

  localparam int DQ_BITS  = 128;
  localparam int ROW_BITS = 14;
  localparam int COL_BITS = 10;

  typedef logic [1:0] op_type_t;
  typedef logic [1:0] data_type_t;

  // 2'b00 and 2'b11 are not valid operations.
  localparam op_type_t OP_READ  = 2'b01;
  localparam op_type_t OP_WRITE = 2'b10;

  localparam data_type_t DATA_TYPE_BYTE  = 2'b00;
  localparam data_type_t DATA_TYPE_HALF  = 2'b01;
  localparam data_type_t DATA_TYPE_WORD  = 2'b10;
  localparam data_type_t DATA_TYPE_BURST = 2'b11;

  typedef struct packed {
    op_type_t              op_type;
    data_type_t            data_type;
    logic [ROW_BITS-1:0]   row_addr;
    logic [COL_BITS-1:0]   col_addr;
  } frontend_command_t;

  localparam int FRONTEND_CMD_BITS = $bits(frontend_command_t);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } fe_slave_state_t;

  function automatic logic is_legal_op(input op_type_t op);
    return (op == OP_READ) || (op == OP_WRITE);
  endfunction

endpackage

// File: rtl/fe_cmd_fifo.sv
// Synchronous show-ahead FIFO for accepted frontend commands.
//   clk, rst      : clock, asynchronous active-high reset
//   i_push/i_wdata: write an entry (ignored when full)
//   i_pop         : drop the head entry (ignored when empty)
//   o_rdata       : current head entry (valid whenever o_empty is 0)
//   o_count       : number of stored entries (0..DEPTH)
//   o_full/o_empty: occupancy flags
module fe_cmd_fifo
  import frontend_command_definition_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_pop,
  output logic [WIDTH-1:0]       o_rdata,
  output logic [$clog2(DEPTH):0] o_count,
  output logic                   o_full,
  output logic                   o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Storage carries no reset; the consumer masks the head while empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_wdata;
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/frontend_cmd_slave.sv
// Responder side of the frontend command interface.
//   clk, power_on_rst          : clock, asynchronous active-high reset
//   valid/command/write_data   : command from the frontend master
//   ba_cmd_pm                  : command permit (ready)
//   read_data/read_data_valid  : in-order read returns to the master
//   be_cmd_valid/be_cmd_ready  : backend command handshake
//   be_op_read/be_row/be_col/be_wdata : backend command fields
//   be_rdata_valid/be_rdata    : in-order read returns from the backend
//   err_illegal_cmd            : pulse, an accepted command had a bad op_type
//   err_unexpected_rdata       : sticky, backend returned data with no credit
//   dbg_state                  : FSM state
//
// Handshakes: a transfer happens on a posedge where valid and ready are both
// high. ba_cmd_pm depends only on registered state, never on valid. The
// backend command and its fields stay stable until be_cmd_ready is seen.
module frontend_cmd_slave #(
  parameter int CMD_BITS    = frontend_command_definition_pkg::FRONTEND_CMD_BITS,
  parameter int DATA_BITS   = frontend_command_definition_pkg::DQ_BITS * 8,
  parameter int ROW_BITS    = frontend_command_definition_pkg::ROW_BITS,
  parameter int COL_BITS    = frontend_command_definition_pkg::COL_BITS,
  parameter int FIFO_DEPTH  = 4,
  parameter int MAX_RD      = 8,
  parameter int INIT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 power_on_rst,
  input  logic                 valid,
  input  logic [CMD_BITS-1:0]  command,
  input  logic [DATA_BITS-1:0] write_data,
  output logic                 ba_cmd_pm,
  output logic [DATA_BITS-1:0] read_data,
  output logic                 read_data_valid,
  output logic                 be_cmd_valid,
  input  logic                 be_cmd_ready,
  output logic                 be_op_read,
  output logic [ROW_BITS-1:0]  be_row,
  output logic [COL_BITS-1:0]  be_col,
  output logic [DATA_BITS-1:0] be_wdata,
  input  logic                 be_rdata_valid,
  input  logic [DATA_BITS-1:0] be_rdata,
  output logic                 err_illegal_cmd,
  output logic                 err_unexpected_rdata,
  output frontend_command_definition_pkg::fe_slave_state_t dbg_state
);
  import frontend_command_definition_pkg::*;

  localparam int RDW = $clog2(MAX_RD + 1);
  localparam int ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int FCW = $clog2(FIFO_DEPTH) + 1;
  localparam int EW  = 1 + ROW_BITS + COL_BITS + DATA_BITS;
  localparam logic [ICW-1:0] INIT_LOAD = ICW'(INIT_CYCLES - 1);

  fe_slave_state_t r_state;
  fe_slave_state_t w_state_nxt;
  logic [ICW-1:0]  r_init_cnt;
  logic            w_run;

  frontend_command_t w_cmd;
  logic              w_is_read;
  logic              w_is_write;
  logic              w_accept;
  logic              w_push;
  logic              w_illegal;
  logic              w_pop;
  logic              w_rd_inc;
  logic              w_rd_dec;
  logic [RDW-1:0]    r_rd_used;

  logic [EW-1:0]        w_fifo_wdata;
  logic [EW-1:0]        w_fifo_rdata;
  logic [FCW-1:0]       w_fifo_count;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_head_rd;
  logic [ROW_BITS-1:0]  w_head_row;
  logic [COL_BITS-1:0]  w_head_col;
  logic [DATA_BITS-1:0] w_head_wdata;

  logic [DATA_BITS-1:0] r_read_data;
  logic                 r_read_data_valid;
  logic                 r_err_illegal;
  logic                 r_err_unexp;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) r_state <= INIT;
    else              r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      INIT:    if (r_init_cnt == '0) w_state_nxt = RUN;
      RUN:     w_state_nxt = RUN;
      default: w_state_nxt = INIT;
    endcase
  end

  always_comb begin
    w_run = 1'b0;
    case (r_state)
      RUN:     w_run = 1'b1;
      default: w_run = 1'b0;
    endcase
  end

  // Loaded with INIT_CYCLES-1 so the permit first rises INIT_CYCLES edges
  // after reset release (the extra edge is the INIT->RUN transition).
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst)                               r_init_cnt <= INIT_LOAD;
    else if (r_state == INIT && r_init_cnt != '0)   r_init_cnt <= r_init_cnt - ICW'(1);
  end

  assign dbg_state = r_state;

  // ---------------- Accept ----------------
  assign w_cmd      = command;
  assign w_is_read  = (w_cmd.op_type == OP_READ);
  assign w_is_write = (w_cmd.op_type == OP_WRITE);

  // Permit uses the pre-pop FIFO count, so a full FIFO blocks a push even
  // when the head pops on the same edge.
  assign ba_cmd_pm = w_run && (w_fifo_count < FCW'(FIFO_DEPTH)) && (r_rd_used < RDW'(MAX_RD));
  assign w_accept  = valid && ba_cmd_pm;
  assign w_push    = w_accept && is_legal_op(w_cmd.op_type);
  assign w_illegal = w_accept && !is_legal_op(w_cmd.op_type);

  assign w_fifo_wdata = {w_is_read, w_cmd.row_addr, w_cmd.col_addr,
                         (w_is_write ? write_data : {DATA_BITS{1'b0}})};

  fe_cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (power_on_rst),
    .i_push  (w_push),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_count (w_fifo_count),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // ---------------- Issue ----------------
  assign {w_head_rd, w_head_row, w_head_col, w_head_wdata} = w_fifo_rdata;

  assign be_cmd_valid = !w_fifo_empty;
  assign w_pop        = be_cmd_valid && be_cmd_ready;
  // Fields are forced to zero while empty so stale storage never shows.
  assign be_op_read   = be_cmd_valid && w_head_rd;
  assign be_row       = be_cmd_valid ? w_head_row   : '0;
  assign be_col       = be_cmd_valid ? w_head_col   : '0;
  assign be_wdata     = be_cmd_valid ? w_head_wdata : '0;

  // ---------------- Read credits ----------------
  assign w_rd_inc = w_accept && w_is_read;
  assign w_rd_dec = be_rdata_valid && (r_rd_used != '0);

  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      r_rd_used <= '0;
    end else begin
      case ({w_rd_inc, w_rd_dec})
        2'b10:   r_rd_used <= r_rd_used + RDW'(1);
        2'b01:   r_rd_used <= r_rd_used - RDW'(1);
        default: r_rd_used <= r_rd_used;
      endcase
    end
  end

  // ---------------- Return and errors ----------------
  always_ff @(posedge clk or posedge power_on_rst) begin
    if (power_on_rst) begin
      r_read_data       <= '0;
      r_read_data_valid <= 1'b0;
      r_err_illegal     <= 1'b0;
      r_err_unexp       <= 1'b0;
    end else begin
      r_read_data_valid <= 1'b0;
      r_err_illegal     <= w_illegal;
      if (be_rdata_valid) begin
        if (r_rd_used != '0) begin
          r_read_data       <= be_rdata;
          r_read_data_valid <= 1'b1;
        end else begin
          r_err_unexp <= 1'b1;
        end
      end
    end
  end

  assign read_data            = r_read_data;
  assign read_data_valid      = r_read_data_valid;
  assign err_illegal_cmd      = r_err_illegal;
  assign err_unexpected_rdata = r_err_unexp;

endmodule

// File: tb/tb_frontend_cmd_slave.sv
module tb_frontend_cmd_slave;
  import frontend_command_definition_pkg::*;

  localparam int DW     = DQ_BITS * 8;
  localparam int RW     = ROW_BITS;
  localparam int CLW    = COL_BITS;
  localparam int INIT_C = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                         power_on_rst;
  logic                         valid;
  logic [FRONTEND_CMD_BITS-1:0] command;
  logic [DW-1:0]                write_data;
  logic                         ba_cmd_pm;
  logic [DW-1:0]                read_data;
  logic                         read_data_valid;
  logic                         be_cmd_valid;
  logic                         be_cmd_ready;
  logic                         be_op_read;
  logic [RW-1:0]                be_row;
  logic [CLW-1:0]               be_col;
  logic [DW-1:0]                be_wdata;
  logic                         be_rdata_valid;
  logic [DW-1:0]                be_rdata;
  logic                         err_illegal_cmd;
  logic                         err_unexpected_rdata;
  fe_slave_state_t              dbg_state;

  logic          bm_valid;
  logic [DW-1:0] bm_data;
  logic          inj_valid;
  logic [DW-1:0] inj_data;

  assign be_rdata_valid = bm_valid | inj_valid;
  assign be_rdata       = bm_valid ? bm_data : inj_data;

  frontend_cmd_slave dut (
    .clk                  (clk),
    .power_on_rst         (power_on_rst),
    .valid                (valid),
    .command              (command),
    .write_data           (write_data),
    .ba_cmd_pm            (ba_cmd_pm),
    .read_data            (read_data),
    .read_data_valid      (read_data_valid),
    .be_cmd_valid         (be_cmd_valid),
    .be_cmd_ready         (be_cmd_ready),
    .be_op_read           (be_op_read),
    .be_row               (be_row),
    .be_col               (be_col),
    .be_wdata             (be_wdata),
    .be_rdata_valid       (be_rdata_valid),
    .be_rdata             (be_rdata),
    .err_illegal_cmd      (err_illegal_cmd),
    .err_unexpected_rdata (err_unexpected_rdata),
    .dbg_state            (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic            rd;
    logic [RW-1:0]   row;
    logic [CLW-1:0]  col;
    logic [DW-1:0]   wdata;
  } be_cmd_t;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } bm_ret_t;

  be_cmd_t       exp_cmd_q[$];
  logic [DW-1:0] exp_q[$];
  bm_ret_t       bm_q[$];
  logic [DW-1:0] fe_mem[int];
  logic [DW-1:0] be_mem[int];
  logic [DW-1:0] last_rd;
  int            n_cmp;
  int            n_bad;
  int            ncyc;
  bit            bm_hold;
  bit            bm_one;

  typedef struct {
    logic [1:0]    op;
    int            row;
    int            col;
    logic [DW-1:0] data;
    logic          exp_bev;
    logic          exp_err;
  } vec_t;

  vec_t tab[10];

  // ---------------- check helpers ----------------
  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0b required=%0b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chkd(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual=%0h required=%0h (low 128 bits)", name, act[127:0], exp[127:0]);
    end
  endtask

  task automatic fail_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: actual=timeout required=event", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_cmd(input logic [1:0] op, input int row, input int col, input logic [DW-1:0] d);
    frontend_command_t fc;
    fc.op_type   = op;
    fc.data_type = DATA_TYPE_WORD;
    fc.row_addr  = RW'(row);
    fc.col_addr  = CLW'(col);
    command      = fc;
    write_data   = d;
  endtask

  // One clock: monitor/backend work at the negedge (handshakes that the
  // coming posedge will complete), then return 1 time unit after posedge.
  task automatic step();
    frontend_command_t fc;
    be_cmd_t           c;
    bm_ret_t           r;
    int                k;
    @(negedge clk);
    if (power_on_rst) begin
      exp_cmd_q.delete();
      exp_q.delete();
      bm_q.delete();
      fe_mem.delete();
      be_mem.delete();
      bm_valid = 1'b0;
    end else begin
      if (read_data_valid) begin
        if (exp_q.size() == 0) chk1("spurious_read_data_valid", read_data_valid, 1'b0);
        else begin
          last_rd = exp_q.pop_front();
          chkd("read_data", read_data, last_rd);
        end
      end
      if (valid && ba_cmd_pm) begin
        fc = command;
        k  = int'({fc.row_addr, fc.col_addr});
        if (fc.op_type == OP_READ) begin
          c.rd = 1'b1; c.row = fc.row_addr; c.col = fc.col_addr; c.wdata = '0;
          exp_cmd_q.push_back(c);
          exp_q.push_back(fe_mem.exists(k) ? fe_mem[k] : '0);
        end else if (fc.op_type == OP_WRITE) begin
          c.rd = 1'b0; c.row = fc.row_addr; c.col = fc.col_addr; c.wdata = write_data;
          exp_cmd_q.push_back(c);
          fe_mem[k] = write_data;
        end
      end
      if (be_cmd_valid && be_cmd_ready) begin
        if (exp_cmd_q.size() == 0) chk1("spurious_be_cmd", be_cmd_valid, 1'b0);
        else begin
          c = exp_cmd_q.pop_front();
          chk1("be_op_read", be_op_read, c.rd);
          chki("be_row", int'(be_row), int'(c.row));
          chki("be_col", int'(be_col), int'(c.col));
          chkd("be_wdata", be_wdata, c.wdata);
        end
        k = int'({be_row, be_col});
        if (be_op_read) begin
          r.due  = ncyc + 3;
          r.data = be_mem.exists(k) ? be_mem[k] : '0;
          bm_q.push_back(r);
        end else begin
          be_mem[k] = be_wdata;
        end
      end
      bm_valid = 1'b0;
      if (bm_q.size() > 0 && (bm_one || (!bm_hold && bm_q[0].due <= ncyc))) begin
        bm_valid = 1'b1;
        bm_data  = bm_q[0].data;
        void'(bm_q.pop_front());
        bm_one   = 1'b0;
      end
    end
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input string name);
    valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      if (ba_cmd_pm) begin
        step();
        valid = 1'b0;
        return;
      end
      step();
    end
    valid = 1'b0;
    fail_timeout(name);
  endtask

  task automatic drain(input string name);
    valid = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_cmd_q.size() == 0 && exp_q.size() == 0 && bm_q.size() == 0) return;
      step();
    end
    fail_timeout(name);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: actual=time limit required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int first;
    int acc;
    power_on_rst = 1'b1;
    valid        = 1'b0;
    command      = '0;
    write_data   = '0;
    be_cmd_ready = 1'b0;
    inj_valid    = 1'b0;
    inj_data     = '0;
    bm_valid     = 1'b0;
    bm_data      = '0;
    bm_hold      = 1'b0;
    bm_one       = 1'b0;
    last_rd      = '0;
    n_cmp        = 0;
    n_bad        = 0;
    ncyc         = 0;

    tab[0] = '{OP_WRITE, 3, 5, DW'(64'h35), 1'b1, 1'b0};
    tab[1] = '{OP_READ, 3, 5, DW'(64'hFFFF), 1'b1, 1'b0};
    tab[2] = '{OP_WRITE, 7, 2, DW'({$urandom, $urandom}), 1'b1, 1'b0};
    tab[3] = '{2'b00, 1, 1, DW'(64'hBAD), 1'b0, 1'b1};
    tab[4] = '{OP_READ, 7, 2, '0, 1'b1, 1'b0};
    tab[5] = '{OP_WRITE, 0, 0, DW'({$urandom, $urandom, $urandom}), 1'b1, 1'b0};
    tab[6] = '{OP_READ, 0, 0, '0, 1'b1, 1'b0};
    tab[7] = '{2'b11, 2, 2, '0, 1'b0, 1'b1};
    tab[8] = '{OP_WRITE, (1 << RW) - 1, (1 << CLW) - 1, ~DW'(0), 1'b1, 1'b0};
    tab[9] = '{OP_READ, (1 << RW) - 1, (1 << CLW) - 1, '0, 1'b1, 1'b0};

    repeat (3) step();

    // Reset values
    chk1("rst_ba_cmd_pm", ba_cmd_pm, 1'b0);
    chk1("rst_be_cmd_valid", be_cmd_valid, 1'b0);
    chk1("rst_read_data_valid", read_data_valid, 1'b0);
    chk1("rst_err_illegal", err_illegal_cmd, 1'b0);
    chk1("rst_err_unexpected", err_unexpected_rdata, 1'b0);
    chkd("rst_read_data", read_data, '0);
    chkd("rst_be_wdata", be_wdata, '0);
    chki("rst_be_row", int'(be_row), 0);
    chki("rst_be_col", int'(be_col), 0);
    chk1("rst_be_op_read", be_op_read, 1'b0);

    // Init window: valid held high from reset release
    set_cmd(OP_WRITE, 1, 1, DW'(64'h11));
    valid        = 1'b1;
    power_on_rst = 1'b0;
    first        = -1;
    chk1("init_pm_at_release", ba_cmd_pm, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      step();
      if (ba_cmd_pm) begin
        first = k;
        break;
      end
    end
    chki("init_first_permit_cycle", first, INIT_C);
    chk1("init_state_run", dbg_state == RUN, 1'b1);
    step();
    valid = 1'b0;
    chk1("init_be_valid_latency", be_cmd_valid, 1'b1);
    be_cmd_ready = 1'b1;
    drain("init_drain");

    // Table-driven command stream with a ready backend
    for (int i = 0; i < 10; i++) begin
      set_cmd(tab[i].op, tab[i].row, tab[i].col, tab[i].data);
      send($sformatf("tab%0d_accept", i));
      chk1($sformatf("tab%0d_be_cmd_valid", i), be_cmd_valid, tab[i].exp_bev);
      chk1($sformatf("tab%0d_err_illegal", i), err_illegal_cmd, tab[i].exp_err);
      step();
      chk1($sformatf("tab%0d_err_illegal_clear", i), err_illegal_cmd, 1'b0);
    end
    drain("tab_drain");

    // Backpressure: 6 writes with the backend stalled
    be_cmd_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      set_cmd(OP_WRITE, 20 + acc, acc, DW'(64'h100 + acc));
      valid = 1'b1;
      if (ba_cmd_pm) acc++;
      step();
    end
    chki("bp_accepted_while_stalled", acc, 4);
    chk1("bp_pm_low_when_full", ba_cmd_pm, 1'b0);
    chki("bp_head_row", int'(be_row), 20);
    step();
    step();
    chki("bp_head_row_stable", int'(be_row), 20);
    chk1("bp_head_valid_stable", be_cmd_valid, 1'b1);
    be_cmd_ready = 1'b1;
    for (int c = 0; c < 30; c++) begin
      if (acc >= 6) break;
      set_cmd(OP_WRITE, 20 + acc, acc, DW'(64'h100 + acc));
      valid = 1'b1;
      if (ba_cmd_pm) acc++;
      step();
    end
    valid = 1'b0;
    chki("bp_total_accepted", acc, 6);
    drain("bp_drain");

    // Credit limit: reads with backend returns withheld
    bm_hold = 1'b1;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      set_cmd(OP_READ, 20 + (acc % 6), acc % 6, '0);
      valid = 1'b1;
      if (ba_cmd_pm) acc++;
      step();
    end
    chki("cr_accepted_at_limit", acc, 8);
    chk1("cr_pm_low_at_limit", ba_cmd_pm, 1'b0);
    bm_one = 1'b1;
    step();
    chk1("cr_pm_back_after_return", ba_cmd_pm, 1'b1);
    chk1("cr_read_data_valid", read_data_valid, 1'b1);
    step();
    valid = 1'b0;
    chk1("cr_pm_low_after_9th", ba_cmd_pm, 1'b0);
    bm_hold = 1'b0;
    drain("cr_drain");

    // Backend return with no outstanding read
    inj_data  = DW'(64'hDEAD);
    inj_valid = 1'b1;
    step();
    inj_valid = 1'b0;
    chk1("ux_no_read_data_valid", read_data_valid, 1'b0);
    chk1("ux_err_set", err_unexpected_rdata, 1'b1);
    chkd("ux_read_data_held", read_data, last_rd);
    repeat (3) step();
    chk1("ux_err_sticky", err_unexpected_rdata, 1'b1);

    // Reset with 3 commands queued
    be_cmd_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(OP_WRITE, 40 + i, i, DW'(64'h400 + i));
      send("mr_fill");
    end
    chk1("mr_be_valid_before_reset", be_cmd_valid, 1'b1);
    power_on_rst = 1'b1;
    #1;
    chk1("mr_ba_cmd_pm", ba_cmd_pm, 1'b0);
    chk1("mr_be_cmd_valid", be_cmd_valid, 1'b0);
    chki("mr_be_row", int'(be_row), 0);
    chki("mr_be_col", int'(be_col), 0);
    chkd("mr_be_wdata", be_wdata, '0);
    chkd("mr_read_data", read_data, '0);
    chk1("mr_err_unexpected", err_unexpected_rdata, 1'b0);
    chk1("mr_state_init", dbg_state == INIT, 1'b1);
    step();
    step();
    power_on_rst = 1'b0;
    inj_valid    = 1'b1;
    step();
    inj_valid = 1'b0;
    chk1("mr_late_return_err", err_unexpected_rdata, 1'b1);
    set_cmd(OP_WRITE, 50, 7, DW'(64'h5057));
    send("mr_accept");
    chki("mr_first_issued_row", int'(be_row), 50);
    be_cmd_ready = 1'b1;
    drain("mr_drain");

    chki("end_cmd_queue_empty", exp_cmd_q.size(), 0);
    chki("end_read_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/frontend_cmd_slave.md
# frontend_cmd_slave

Responder side of the frontend command interface. Accepts `frontend_command_t` commands and 1024-bit write data from the frontend master using the `valid`/`ba_cmd_pm` handshake. Buffers them in a small command FIFO and issues them in order to the bank-level backend. Returns backend read data to the master in order on `read_data`/`read_data_valid`, gated by a read-credit counter so that read responses can never be lost.

## Interface
Parameters:
- `CMD_BITS`, `FRONTEND_CMD_BITS`: width of the packed `frontend_command_t`.
- `DATA_BITS`, `DQ_BITS*8`: write/read data width.
- `ROW_BITS`, `ROW_BITS`: row address width.
- `COL_BITS`, `COL_BITS`: column address width.
- `FIFO_DEPTH`, 4: command FIFO entries (power of 2, ≥2).
- `MAX_RD`, 8: maximum accepted-but-unreturned reads.
- `INIT_CYCLES`, 16: cycles after reset before the first command is accepted.

Ports:
- `clk` in 1: single clock, all logic on posedge.
- `power_on_rst` in 1: asynchronous, active-high reset.
- `valid` in 1: master command valid.
- `command` in CMD_BITS: packed `frontend_command_t` (op_type, data_type, row_addr, col_addr).
- `write_data` in DATA_BITS: data for OP_WRITE, sampled with the command.
- `ba_cmd_pm` out 1: ready / command permit.
- `read_data` out DATA_BITS: returned read data.
- `read_data_valid` out 1: one-cycle pulse per returned read.
- `be_cmd_valid` out 1: backend command valid.
- `be_cmd_ready` in 1: backend accepts the command.
- `be_op_read` out 1: 1 = read, 0 = write.
- `be_row` out ROW_BITS, `be_col` out COL_BITS: backend address.
- `be_wdata` out DATA_BITS: backend write data.
- `be_rdata_valid` in 1, `be_rdata` in DATA_BITS: backend read return (in order).
- `err_illegal_cmd` out 1: one-cycle pulse; an accepted command had an op_type other than OP_READ/OP_WRITE.
- `err_unexpected_rdata` out 1: sticky; `be_rdata_valid` arrived while the credit count was 0.

## Operation
FSM, states INIT and RUN:
- Reset enters INIT and loads the init counter with INIT_CYCLES-1. The counter decrements each cycle.
- At 0 the FSM moves to RUN. RUN is left only by reset.

Permit:
- `ba_cmd_pm` = RUN && fifo_count < FIFO_DEPTH && rd_used < MAX_RD.
- It is a combinational function of registered state only and never depends on `valid`.

Accept:
- A command is accepted on a posedge where `valid && ba_cmd_pm`.
- OP_WRITE and OP_READ push {op, row, col, write_data} into the FIFO. OP_READ also increments `rd_used`.
- Any other op_type is consumed without a push, and `err_illegal_cmd` pulses in the next cycle.

Issue:
- `be_cmd_valid` = FIFO non-empty. The `be_*` fields come from the FIFO head (show-ahead).
- On a posedge with `be_cmd_valid && be_cmd_ready` the FIFO pops.
- `be_wdata` holds the stored data for writes and 0 for reads.

Return:
- On a posedge with `be_rdata_valid` and rd_used > 0: `read_data <= be_rdata`, `read_data_valid <= 1`, and rd_used decrements.
- If rd_used == 0: data is dropped, `err_unexpected_rdata` is set, and the counter is unchanged.

Widths:
- `rd_used` is $clog2(MAX_RD+1) bits and never wraps.
- The FIFO read/write pointers are log2(FIFO_DEPTH) bits and wrap modulo the depth.
- `fifo_count` is log2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values:
  - `ba_cmd_pm`, `be_cmd_valid`, `read_data_valid`, `err_illegal_cmd`, `err_unexpected_rdata` = 0.
  - `read_data`, `be_wdata`, `be_row`, `be_col` = 0; `be_op_read` = 0.
  - FIFO empty, rd_used = 0.
- The first `ba_cmd_pm` goes high exactly INIT_CYCLES cycles after reset deassertion.
- Accept at edge N: `be_cmd_valid` high from N+1 (1-cycle latency, no bypass path).
- `be_rdata_valid` at edge M: `read_data_valid` is high for the single cycle after M, and `read_data` holds its value until the next return.
- Simultaneous push and pop when full: the push is blocked, because the permit reflects the pre-pop count. When neither empty nor full, count is unchanged and the pointers advance.
- Simultaneous read accept and read return: rd_used is unchanged. At rd_used == MAX_RD a same-cycle return does not raise the permit until the next cycle.
- `be_cmd_valid` and its fields are held stable until `be_cmd_ready`.
- Reset mid-operation: FIFO contents and credits are discarded and the FSM returns to INIT. Backend returns arriving after reset set `err_unexpected_rdata`.

## Structure
- `frontend_command_definition_pkg` supplies `frontend_command_t`, OP_READ, OP_WRITE and DATA_TYPE_*. This block adds no new command types.
- Add `fe_slave_state_t` {INIT, RUN} to the same package.
- One sub-module: `fe_cmd_fifo` (parameterised synchronous FIFO with show-ahead, count, and full/empty flags).

## Test plan
- **Init window:** release reset with `valid` held at 1 and INIT_CYCLES=16 → `ba_cmd_pm` stays 0 for 16 cycles; the first accept happens at cycle 16.
- **Write/read round trip:**
  - Write row 3, col 5, data 0x35, then read row 3, col 5, with `be_cmd_ready`=1.
  - Backend model returns 0x35 three cycles after the read issue.
  - Required: `be_cmd_valid` one cycle after each accept; `read_data_valid` pulses once with 0x35.
- **Backpressure full:** `be_cmd_ready`=0, issue 6 writes → only 4 are accepted and `ba_cmd_pm` drops after the 4th. Raising ready drains rows/cols in order and accepts the remaining 2.
- **Credit limit:**
  - Send 9 reads with no backend returns → `ba_cmd_pm` drops after 8.
  - A single `be_rdata_valid` coinciding with a `valid` cycle → permit reappears the following cycle; the 9th read is accepted.
- **Errors:**
  - op_type illegal → no backend command; `err_illegal_cmd` pulses once.
  - `be_rdata_valid` with rd_used=0 → no `read_data_valid`; `err_unexpected_rdata` latched until reset.
- **Mid-run reset:** assert `power_on_rst` with 3 commands queued → all outputs return to 0 and the queue is empty. After INIT the first new command is the first one issued.
